// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the multi-port register file and its scoreboard.
package regfile_pkg;

  localparam int DEFAULT_XLEN  = 32;
  localparam int DEFAULT_NREGS = 32;
  localparam int DEFAULT_AW    = $clog2(DEFAULT_NREGS);

  typedef logic [DEFAULT_AW-1:0]   reg_addr_t;
  typedef logic [DEFAULT_XLEN-1:0] reg_data_t;

  localparam int        ZERO_REG_ADDR = 0;
  localparam reg_data_t ZERO_REG_DATA = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write busy bits, set by issue and cleared by writeback (set wins),
// with a combinational lookup for each captured read address.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = DEFAULT_NREGS,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_rd,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic [NUM_RD*AW-1:0] cap_addr,
  output logic [NUM_RD-1:0]    rs_busy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Clears are applied before the set so a newly issued producer keeps its bit.
  always_comb begin
    busy_nxt = busy;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
    end
    if (iss_en) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[ZERO_REG_ADDR] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  always_comb begin
    rs_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rs_busy[p] = busy[cap_addr[p*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file, registered reads, x0 hardwired to zero, integrated scoreboard.
// Build option REGFILE_BYPASS_EN: same-cycle write/read of one address returns the new data (write-first).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = DEFAULT_XLEN,
  parameter int NREGS  = DEFAULT_NREGS,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rs_rd_en,
  input  logic [NUM_RD*AW-1:0]   rs_addr,
  output logic [NUM_RD*XLEN-1:0] rs_data,
  output logic [NUM_RD-1:0]      rs_busy,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_rd,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data
);

  // No valid/ready handshake: every enabled write and every issue is accepted in the cycle it is presented.

  logic [XLEN-1:0] mem [NREGS];
  logic [XLEN-1:0] rd_val [NUM_RD];
  logic [NUM_RD*AW-1:0] cap_addr;

  // Later ports overwrite earlier ones in the loop, so port 1 wins on a shared address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= XLEN'(ZERO_REG_DATA);
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && int'(wr_addr[w*AW +: AW]) != ZERO_REG_ADDR)
          mem[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rd_val = '{default: '0};
    for (int p = 0; p < NUM_RD; p++) begin
      rd_val[p] = mem[rs_addr[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && wr_addr[w*AW +: AW] == rs_addr[p*AW +: AW])
          rd_val[p] = wr_data[w*XLEN +: XLEN];
      end
`endif
      if (int'(rs_addr[p*AW +: AW]) == ZERO_REG_ADDR) rd_val[p] = XLEN'(ZERO_REG_DATA);
    end
  end

  // Captured addresses and data hold while rs_rd_en is low (decode stall).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr <= '0;
      rs_data  <= '0;
    end else if (rs_rd_en) begin
      cap_addr <= rs_addr;
      for (int p = 0; p < NUM_RD; p++) rs_data[p*XLEN +: XLEN] <= rd_val[p];
    end
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR),
    .AW     (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .cap_addr (cap_addr),
    .rs_busy  (rs_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed test of regfile_mp (2 read ports, 2 write ports, 32 x 32-bit).
module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int AW     = 5;

  logic                   clk;
  logic                   rst_n;
  logic                   rs_rd_en;
  logic [NUM_RD*AW-1:0]   rs_addr;
  logic [NUM_RD*XLEN-1:0] rs_data;
  logic [NUM_RD-1:0]      rs_busy;
  logic                   iss_en;
  logic [AW-1:0]          iss_rd;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;

  int n_checks;
  int n_fail;
  logic [63:0] exp_q[$];

  regfile_mp #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs_rd_en (rs_rd_en),
    .rs_addr  (rs_addr),
    .rs_data  (rs_data),
    .rs_busy  (rs_busy),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks: inputs change 1 time unit after the rising edge, outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_rd_en = 1'b0;
    iss_en   = 1'b0;
    iss_rd   = '0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
  endtask

  task automatic wr(input int port, input int addr, input logic [31:0] data);
    wr_en[port]              = 1'b1;
    wr_addr[port*AW +: AW]   = AW'(addr);
    wr_data[port*XLEN +: XLEN] = data;
  endtask

  task automatic rd(input int a0, input int a1);
    rs_rd_en = 1'b1;
    rs_addr  = {AW'(a1), AW'(a0)};
  endtask

  task automatic issue(input int addr);
    iss_en = 1'b1;
    iss_rd = AW'(addr);
  endtask

  // Scoreboard
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_data(input logic [31:0] p0, input logic [31:0] p1);
    exp_q.push_back({p1, p0});
  endtask

  task automatic check_data(input string tag);
    logic [63:0] e;
    e = exp_q.pop_front();
    check(tag, 64'(rs_data), e);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rs_addr  = '0;
    idle();
    rst_n = 1'b0;
    repeat (3) tick();
    expect_data(32'h0, 32'h0);
    check_data("reset_rs_data");
    check("reset_rs_busy", 64'(rs_busy), 64'h0);
    rst_n = 1'b1;

    // Every address reads zero after reset
    for (int a = 0; a < NREGS; a++) begin
      rd(a, NREGS - 1 - a);
      tick();
      expect_data(32'h0, 32'h0);
      check_data($sformatf("post_reset_read_%0d", a));
      check($sformatf("post_reset_busy_%0d", a), 64'(rs_busy), 64'h0);
    end
    idle();

    // Reset during a write and an issue to register 6
    wr(0, 6, 32'h0000_0055);
    issue(6);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    rd(6, 0);
    tick();
    expect_data(32'h0, 32'h0);
    check_data("reset_mid_write_data");
    check("reset_mid_write_busy", 64'(rs_busy), 64'h0);
    idle();

    // Basic write then read
    wr(0, 5, 32'hDEAD_BEEF);
    tick();
    idle();
    rd(5, 0);
    tick();
    expect_data(32'hDEAD_BEEF, 32'h0);
    check_data("write5_read");
    idle();

    // Write to register 0 is discarded
    wr(1, 0, 32'h0000_1234);
    tick();
    idle();
    rd(0, 5);
    tick();
    expect_data(32'h0, 32'hDEAD_BEEF);
    check_data("write0_discarded");
    idle();

    // Stall: rs_rd_en low holds data even when address changes
    rs_addr = {AW'(0), AW'(5)};
    tick();
    expect_data(32'h0, 32'hDEAD_BEEF);
    check_data("stall_hold");

    // Same-cycle write and read of address 7
    wr(0, 7, 32'h0000_0011);
    tick();
    idle();
    wr(0, 7, 32'hA5A5_A5A5);
    rd(7, 5);
    tick();
`ifdef REGFILE_BYPASS_EN
    expect_data(32'hA5A5_A5A5, 32'hDEAD_BEEF);
`else
    expect_data(32'h0000_0011, 32'hDEAD_BEEF);
`endif
    check_data("same_cycle_rw7");
    idle();
    rd(7, 7);
    tick();
    expect_data(32'hA5A5_A5A5, 32'hA5A5_A5A5);
    check_data("after_rw7");
    idle();

    // Both write ports on address 9: port 1 wins
    wr(0, 9, 32'h0000_0001);
    wr(1, 9, 32'h0000_0002);
    tick();
    idle();
    rd(9, 0);
    tick();
    expect_data(32'h0000_0002, 32'h0);
    check_data("dual_write9");
    idle();

    // Dual write to 9 while capturing 9
    wr(0, 9, 32'h0000_0003);
    wr(1, 9, 32'h0000_0004);
    rd(0, 9);
    tick();
`ifdef REGFILE_BYPASS_EN
    expect_data(32'h0, 32'h0000_0004);
`else
    expect_data(32'h0, 32'h0000_0002);
`endif
    check_data("dual_write9_bypass");
    idle();
    rd(9, 0);
    tick();
    expect_data(32'h0000_0004, 32'h0);
    check_data("dual_write9_after");
    idle();

    // Issue 3, capture 3, then writeback during stall
    issue(3);
    tick();
    idle();
    rd(3, 0);
    tick();
    check("busy3_set", 64'(rs_busy), 64'h1);
    expect_data(32'h0, 32'h0);
    check_data("busy3_data");
    idle();
    wr(1, 3, 32'h0000_0033);
    tick();
    idle();
    check("busy3_cleared", 64'(rs_busy), 64'h0);
    expect_data(32'h0, 32'h0);
    check_data("busy3_data_held");
    rd(3, 3);
    tick();
    expect_data(32'h0000_0033, 32'h0000_0033);
    check_data("read3_new");
    idle();

    // Issue and write address 4 in the same cycle: set wins
    issue(4);
    wr(0, 4, 32'h0000_0044);
    tick();
    idle();
    rd(4, 0);
    tick();
    check("busy4_set_wins", 64'(rs_busy), 64'h1);
    expect_data(32'h0000_0044, 32'h0);
    check_data("data4");
    idle();
    wr(1, 4, 32'h0000_0045);
    tick();
    idle();
    check("busy4_cleared", 64'(rs_busy), 64'h0);

    // Issue on port 1 lookup
    issue(10);
    tick();
    idle();
    rd(0, 10);
    tick();
    check("busy10_port1", 64'(rs_busy), 64'h2);
    idle();
    wr(0, 10, 32'h0000_00AA);
    tick();
    idle();
    check("busy10_cleared", 64'(rs_busy), 64'h0);

    // Issue of register 0 is never busy
    issue(0);
    tick();
    idle();
    rd(0, 0);
    tick();
    check("busy0_never", 64'(rs_busy), 64'h0);
    idle();

    // Reset clears stored data and pending bits
    issue(12);
    tick();
    idle();
    rst_n = 1'b0;
    #2;
    check("async_reset_data", 64'(rs_data), 64'h0);
    tick();
    rst_n = 1'b1;
    rd(5, 12);
    tick();
    expect_data(32'h0, 32'h0);
    check_data("reset_clears_regs");
    check("reset_clears_busy", 64'(rs_busy), 64'h0);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
